hazard_ctrl: RTL and testbench

Pipeline interlock controller between the ID stage and the register file's write-back port. It tracks every in-flight register write issued from ID in a shift-register scoreboard whose depth is the ID-to-WB latency. When the instruction in ID reads a register still pending write-back, it stalls IF/ID. It also absorbs branch flushes and external (memory) stalls, and keeps a saturating stall counter for performance measurement.

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_wb_tracker.sv | 59 +++++
 rtl/hazard_ctrl.sv | 71 +++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the ID/WB interlock.
// The HAZARD_WB_BYPASS_EN macro (used in hazard_ctrl) picks how many scoreboard entries are checked.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int PIPE_WB_LAT  = 3;

    localparam bit ENABLE  = 1'b1;
    localparam bit DISABLE = 1'b0;

    // With a write-through register file the entry retiring this cycle is already visible.
    function automatic int chk_depth(input int wb_lat, input bit bypass);
        return bypass ? wb_lat - 1 : wb_lat;
    endfunction

endpackage

// File: rtl/hazard_ctrl_wb_tracker.sv
// Shift-register scoreboard of in-flight register writes, with two read-port address matches.
// Entry 0 is the youngest write; entry WB_LAT-1 is the one writing back this cycle.
module hazard_ctrl_wb_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT    = PIPE_WB_LAT,
    parameter int ADDR_W    = REG_ADDR_LEN,
    parameter int CHK_DEPTH = PIPE_WB_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 ins_v,
    input  logic [ADDR_W-1:0]    ins_addr,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [ADDR_W-1:0]    b_addr,
    output logic                 match_a,
    output logic                 match_b,
    output logic [2**ADDR_W-1:0] busy_mask
);

    logic [WB_LAT-1:0] ent_v;
    logic [ADDR_W-1:0] ent_addr [WB_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_v <= '0;
            for (int i = 0; i < WB_LAT; i++) ent_addr[i] <= '0;
        end else if (!hold) begin
            ent_v[0]    <= ins_v;
            ent_addr[0] <= ins_addr;
            for (int i = 1; i < WB_LAT; i++) begin
                ent_v[i]    <= ent_v[i-1];
                ent_addr[i] <= ent_addr[i-1];
            end
        end
    end

    // Register 0 is hard-wired, so it never matches.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int i = 0; i < CHK_DEPTH; i++) begin
            if (ent_v[i] && ent_addr[i] == a_addr) match_a = 1'b1;
            if (ent_v[i] && ent_addr[i] == b_addr) match_b = 1'b1;
        end
        if (a_addr == '0) match_a = 1'b0;
        if (b_addr == '0) match_b = 1'b0;
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (ent_v[i]) busy_mask[ent_addr[i]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage interlock: stalls IF/ID on a read of a pending write, absorbs flush and external stall,
// and counts hazard stall cycles. Define HAZARD_WB_BYPASS_EN for a write-through register file.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT = PIPE_WB_LAT,
    parameter int ADDR_W = REG_ADDR_LEN,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 rs_rd,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic                 rt_rd,
    input  logic [ADDR_W-1:0]    rt_addr,
    input  logic                 rd_wr,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 flush,
    input  logic                 ext_stall,
    output logic                 stall_id,
    output logic                 issue,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic [CNT_W-1:0]     stall_cnt
);

`ifdef HAZARD_WB_BYPASS_EN
    localparam bit BYPASS = ENABLE;
`else
    localparam bit BYPASS = DISABLE;
`endif
    localparam int CHK_DEPTH = chk_depth(WB_LAT, BYPASS);

    logic match_a;
    logic match_b;
    logic hazard;
    logic ins_v;
    logic count_en;

    assign hazard   = (rs_rd & match_a) | (rt_rd & match_b);
    assign stall_id = ext_stall | (id_valid & hazard & ~flush);
    assign issue    = id_valid & ~flush & ~ext_stall & ~hazard;
    assign ins_v    = issue & rd_wr & (rd_addr != '0);
    assign count_en = id_valid & hazard & ~flush & ~ext_stall;

    hazard_ctrl_wb_tracker #(
        .WB_LAT    (WB_LAT),
        .ADDR_W    (ADDR_W),
        .CHK_DEPTH (CHK_DEPTH)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .hold      (ext_stall),
        .ins_v     (ins_v),
        .ins_addr  (rd_addr),
        .a_addr    (rs_addr),
        .b_addr    (rt_addr),
        .match_a   (match_a),
        .match_b   (match_b),
        .busy_mask (busy_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (count_en && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (WB_LAT=3, CNT_W=4 so saturation is reachable).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic        rs_rd = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic        rt_rd = 1'b0;
    logic [4:0]  rt_addr = '0;
    logic        rd_wr = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        ext_stall = 1'b0;
    logic        stall_id;
    logic        issue;
    logic [31:0] busy_mask;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int failures = 0;

`ifdef HAZARD_WB_BYPASS_EN
    localparam int NST = 2;
`else
    localparam int NST = 3;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.WB_LAT(3), .ADDR_W(5), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .rs_rd     (rs_rd),
        .rs_addr   (rs_addr),
        .rt_rd     (rt_rd),
        .rt_addr   (rt_addr),
        .rd_wr     (rd_wr),
        .rd_addr   (rd_addr),
        .flush     (flush),
        .ext_stall (ext_stall),
        .stall_id  (stall_id),
        .issue     (issue),
        .busy_mask (busy_mask),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic a_rd, input logic [4:0] a,
                          input logic b_rd, input logic [4:0] b,
                          input logic w, input logic [4:0] d,
                          input logic fl, input logic es);
        id_valid = v; rs_rd = a_rd; rs_addr = a; rt_rd = b_rd; rt_addr = b;
        rd_wr = w; rd_addr = d; flush = fl; ext_stall = es;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // reset with a reader of r5 in ID
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_id), 32'd0);
        chk("rst_issue", 32'(issue), 32'd1);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        cyc();

        // back-to-back dependency on r8
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 8, 0, 0);
        #1 chk("dep_prod_issue", 32'(issue), 32'd1);
        cyc();
        for (int k = 0; k <= NST; k++) begin
            set_in(1, 1, 8, 0, 0, 0, 0, 0, 0);
            #1;
            chk("dep_stall", 32'(stall_id), 32'(k < NST));
            chk("dep_issue", 32'(issue), 32'(k == NST));
            if (k == 0) chk("dep_busy", busy_mask, 32'h100);
            cyc();
        end
        idle();
        #1 chk("dep_cnt", 32'(stall_cnt), 32'(NST));

        // r0 never creates a hazard or busy bit
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc();
        set_in(1, 1, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("r0_stall", 32'(stall_id), 32'd0);
        chk("r0_issue", 32'(issue), 32'd1);
        chk("r0_busy", busy_mask, 32'd0);
        cyc();

        // flush in the second stall cycle; r8 still retires on schedule
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 8, 0, 0);
        cyc();
        set_in(1, 1, 8, 0, 0, 1, 9, 0, 0);
        #1 chk("fl_stall1", 32'(stall_id), 32'd1);
        cyc();
        set_in(1, 1, 8, 0, 0, 1, 9, 1, 0);
        #1;
        chk("fl_stall", 32'(stall_id), 32'd0);
        chk("fl_issue", 32'(issue), 32'd0);
        chk("fl_busy", busy_mask, 32'h100);
        cyc();
        idle();
        #1;
        chk("fl_bubble_busy", busy_mask, 32'h100);
        chk("fl_cnt", 32'(stall_cnt), 32'd1);
        cyc();
        chk("fl_retired", busy_mask, 32'd0);

        // ext_stall freezes the scoreboard and the counter
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 3, 0, 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 1, 3, 0, 0, 0, 0, 0, 1);
            #1;
            chk("es_stall", 32'(stall_id), 32'd1);
            chk("es_issue", 32'(issue), 32'd0);
            chk("es_busy", busy_mask, 32'h8);
            chk("es_cnt", 32'(stall_cnt), 32'd0);
            cyc();
        end
        for (int k = 0; k <= NST; k++) begin
            set_in(1, 1, 3, 0, 0, 0, 0, 0, 0);
            #1;
            chk("es_after_stall", 32'(stall_id), 32'(k < NST));
            chk("es_after_issue", 32'(issue), 32'(k == NST));
            cyc();
        end
        idle();
        #1 chk("es_cnt_final", 32'(stall_cnt), 32'(NST));

        // rt port hazard and reset mid-operation
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 17, 0, 0);
        cyc();
        set_in(1, 1, 2, 1, 17, 0, 0, 0, 0);
        #1 chk("rt_stall", 32'(stall_id), 32'd1);
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
        set_in(1, 1, 2, 1, 17, 0, 0, 0, 0);
        #1;
        chk("mid_rst_busy", busy_mask, 32'd0);
        chk("mid_rst_issue", 32'(issue), 32'd1);
        chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        cyc();

        // self-dependent instruction stream drives the counter to saturation
        do_reset();
        set_in(1, 1, 4, 0, 0, 1, 4, 0, 0);
        for (int k = 0; k < 4; k++) cyc();
        chk("sat_early", 32'(stall_cnt), 32'(NST));
        for (int k = 0; k < 36; k++) cyc();
        chk("sat_cnt", 32'(stall_cnt), 32'd15);
        for (int k = 0; k < 4; k++) cyc();
        chk("sat_hold", 32'(stall_cnt), 32'd15);
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
